// File: rtl/eight_way_rr_arbiter.sv
// Eight-requester arbiter with selectable fixed-priority / round-robin selection,
// registered one-hot grant, maximum hold time and a one-cycle gap between grants.
module eight_way_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16  // 2..255, 0 disables the hold timeout
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    localparam bit         HOLD_EN    = (MAX_HOLD != 0);

    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       timeout_q, timeout_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [2:0] last_q, last_d;

    logic [2:0] fp_idx;
    logic [7:0] rr_req;
    logic [2:0] rr_off;
    logic [2:0] rr_idx;
    logic [2:0] win_idx;
    logic [7:0] win_oh;
    logic       win_any;
    logic       arb_ok;
    logic       release_now;
    logic       expire_now;

    // Fixed priority: the last matching index in an ascending scan is the highest one.
    always_comb begin
        fp_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) begin
                fp_idx = 3'(i);
            end
        end
    end

    // rr_req[k] is the request that sits k+1 places after the last released index.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rr_rotate
            assign rr_req[gi] = req[last_q + 3'(gi + 1)];
        end
    endgenerate

    always_comb begin
        rr_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rr_req[i]) begin
                rr_off = 3'(i);
            end
        end
    end

    assign rr_idx  = last_q + rr_off + 3'd1;
    assign win_idx = mode ? rr_idx : fp_idx;
    assign win_any = |req;
    assign arb_ok  = en && win_any;

    generate
        for (gi = 0; gi < 8; gi++) begin : g_win_decode
            assign win_oh[gi] = (win_idx == 3'(gi));
        end
    endgenerate

    // A requester dropping its line or en going low wins over an expiring hold.
    assign release_now = !en || !req[gnt_idx_q];
    assign expire_now  = HOLD_EN && (hold_cnt_q == HOLD_LIMIT);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        last_d      = last_q;

        case (state_q)
            IDLE, GAP: begin
                if (arb_ok) begin
                    state_d     = GRANT;
                    gnt_d       = win_oh;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = 8'd1;
                end else begin
                    state_d     = IDLE;
                    gnt_d       = 8'd0;
                    gnt_idx_d   = 3'd0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = 8'd0;
                end
            end

            GRANT: begin
                if (release_now || expire_now) begin
                    state_d     = GAP;
                    gnt_d       = 8'd0;
                    gnt_idx_d   = 3'd0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = 8'd0;
                    last_d      = gnt_idx_q;
                    timeout_d   = expire_now && !release_now;
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d     = IDLE;
                gnt_d       = 8'd0;
                gnt_idx_d   = 3'd0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 8'd0;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= 8'd0;
            last_q      <= 3'd7;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            last_q      <= last_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_eight_way_rr_arbiter.sv
// Directed bench: dut_a uses MAX_HOLD=4, dut_b has the timeout disabled; both share stimulus.
module tb_eight_way_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic [7:0] req;

    logic [7:0] gnt_a, gnt_b;
    logic [2:0] idx_a, idx_b;
    logic       vld_a, vld_b;
    logic       to_a, to_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       mode;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       to;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    eight_way_rr_arbiter #(.MAX_HOLD(4)) dut_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .req(req),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(vld_a), .timeout(to_a)
    );

    eight_way_rr_arbiter #(.MAX_HOLD(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .req(req),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(vld_b), .timeout(to_b)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input bit which, input logic [7:0] eg,
                       input logic [2:0] ei, input logic ev, input logic et);
        logic [7:0] ag;
        logic [2:0] ai;
        logic       av;
        logic       at;
        if (which == 1'b0) begin
            ag = gnt_a; ai = idx_a; av = vld_a; at = to_a;
        end else begin
            ag = gnt_b; ai = idx_b; av = vld_b; at = to_b;
        end
        total++;
        $display("tx %-10s dut_%s req=%b gnt=%b idx=%0d vld=%b to=%b",
                 name, which ? "b" : "a", req, ag, ai, av, at);
        if (ag !== eg || ai !== ei || av !== ev || at !== et) begin
            bad++;
            $display("FAIL %s dut_%s: got gnt=%b idx=%0d vld=%b to=%b, want gnt=%b idx=%0d vld=%b to=%b",
                     name, which ? "b" : "a", ag, ai, av, at, eg, ei, ev, et);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic m, input logic [7:0] rq,
                       input logic [7:0] g, input logic [2:0] i, input logic vl, input logic t);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.req = rq;
        v.gnt = g; v.idx = i; v.vld = vl; v.to = t;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; req = 8'h00;

        // reset, fixed priority, release/regrant, idle with no requests
        add(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 8'h25, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h25, 8'h20, 3'd5, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h05, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h05, 8'h04, 3'd2, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h05, 8'h04, 3'd2, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        // other bits toggling never preempt; drop on the expiry edge is a plain release
        add(1'b0, 1'b1, 1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h1F, 8'h10, 3'd4, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'hF0, 8'h10, 3'd4, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; en = tbl[i].en; mode = tbl[i].mode; req = tbl[i].req;
            step;
            chk($sformatf("tbl%0d", i), 1'b0, tbl[i].gnt, tbl[i].idx, tbl[i].vld, tbl[i].to);
            chk($sformatf("tbl%0d", i), 1'b1, tbl[i].gnt, tbl[i].idx, tbl[i].vld, tbl[i].to);
        end

        // round-robin rotation 0..7,0 with one dead cycle between grants
        rst = 1'b1; step; rst = 1'b0;
        mode = 1'b1; en = 1'b1; req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            logic [7:0] oh;
            oh = 8'h01 << (k % 8);
            step;
            chk("rr_grant", 1'b0, oh, 3'(k % 8), 1'b1, 1'b0);
            chk("rr_grant", 1'b1, oh, 3'(k % 8), 1'b1, 1'b0);
            req = 8'hFF & ~oh;
            step;
            chk("rr_dead", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
            req = 8'hFF;
        end
        req = 8'h00; step;
        chk("rr_idle", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        // timeout in fixed priority: 4 grant cycles, timeout gap, immediate regrant
        mode = 1'b0; req = 8'h80;
        for (int s = 0; s < 4; s++) begin
            step;
            chk("fp_hold", 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
            chk("fp_hold", 1'b1, 8'h80, 3'd7, 1'b1, 1'b0);
        end
        step;
        chk("fp_tmo", 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        chk("fp_notmo", 1'b1, 8'h80, 3'd7, 1'b1, 1'b0);
        step;
        chk("fp_regnt", 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
        req = 8'h00; step; step;
        chk("fp_idle", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        chk("fp_idle", 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);

        // timeout in round-robin: 0 -> timeout -> 7 -> timeout -> 0
        mode = 1'b1; req = 8'h81;
        for (int s = 0; s < 4; s++) begin
            step;
            chk("rr_hold0", 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
        end
        step;
        chk("rr_tmo0", 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        for (int s = 0; s < 4; s++) begin
            step;
            chk("rr_hold7", 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
        end
        step;
        chk("rr_tmo7", 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        step;
        chk("rr_back0", 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
        chk("rr_nto_b", 1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'h00; step; step;
        chk("rr_idle2", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        // en drop releases without timeout and blocks new grants
        mode = 1'b0; req = 8'h08; en = 1'b1;
        step;
        chk("en_gnt3", 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
        en = 1'b0;
        step;
        chk("en_drop", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) begin
            step;
            chk("en_block", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        end
        en = 1'b1;
        step;
        chk("en_regnt", 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);

        // reset mid-grant clears outputs and restarts the round-robin search at 0
        rst = 1'b1; mode = 1'b1; req = 8'h24;
        step;
        chk("rst_mid", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        chk("rst_mid", 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step;
        chk("rst_rr", 1'b0, 8'h04, 3'd2, 1'b1, 1'b0);
        chk("rst_rr", 1'b1, 8'h04, 3'd2, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eight_way_rr_arbiter.md
Name: eight_way_rr_arbiter

Overview:
- Arbitrates one shared resource among eight requesters and produces a registered one-hot grant plus its 3-bit encoded index.
- Selectable fixed-priority mode (bit 7 highest, same priority order as the team's 8-to-3 priority encoder) or round-robin mode.
- Sits in front of any shared datapath unit, for example a bus port or a compute unit.
- Enforces a maximum grant hold time and a one-cycle turnaround between grants.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one grant may stay asserted. Legal range 2..255. A value of 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  arbitration enable. Low blocks new grants and forces release of the current grant.
- mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin.
- req  input  8  request vector. req[i] is held high for as long as requester i wants the resource.
- gnt  output  8  one-hot grant, registered. All zeros when nothing is granted.
- gnt_idx  output  3  binary index of the granted requester. 0 when gnt_valid is low.
- gnt_valid  output  1  high when gnt is non-zero (equals the OR of gnt).
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset, at the first clock edge with rst high:
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - state=IDLE, hold_cnt=0, last=7 (so the first round-robin search starts at index 0).
  - rst overrides every other input, including during an active grant.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If en=1 and req!=0, select a winner, register gnt/gnt_idx/gnt_valid, set hold_cnt=1 and go to GRANT.
  - Latency: req sampled high at edge N gives the grant visible after edge N.
  - Otherwise stay in IDLE with outputs at zero.
- Winner selection, combinational on req, mode and last:
  - mode=0: highest set index.
  - mode=1: first set index searching last+1, last+2, ... modulo 8, wrapping 7 to 0.
  - mode is sampled only at the arbitration edge; changing it mid-grant has no effect on the current grant.
- GRANT, evaluated at each edge:
  - en=0: go to GAP, timeout=0.
  - Otherwise req[gnt_idx]=0: go to GAP, timeout=0. gnt therefore stays high for one cycle after req drops.
  - Otherwise MAX_HOLD!=0 and hold_cnt==MAX_HOLD: go to GAP with timeout=1. gnt is high for exactly MAX_HOLD cycles.
  - Otherwise stay in GRANT and increment hold_cnt, which saturates and never wraps.
  - Simultaneous req drop and hold expiry: treat as a normal release, timeout=0.
  - A change on req bits other than gnt_idx never preempts the current grant.
- Entering GAP:
  - gnt, gnt_idx and gnt_valid go to 0 and last is set to the released index.
  - timeout is high only for that single GAP cycle.
- GAP:
  - Exactly one cycle with no grant.
  - At the end of the GAP cycle, arbitrate exactly as in IDLE using the updated last. A winner gives a new grant in the next cycle; otherwise go to IDLE.
  - Minimum turnaround is one dead cycle between grants.
  - In mode=0 a requester still high after a timeout can be re-granted immediately. In mode=1 it is served last.
- Invariants:
  - gnt is always zero-hot or one-hot.
  - gnt_idx always matches gnt.
  - gnt_valid equals the OR of gnt.
  - No grant is ever issued to a requester whose req was low at the arbitration edge.

Test Plan:
1. Reset and fixed priority:
   - Stimulus: rst for 2 cycles, then en=1, mode=0, req=8'b0010_0101.
   - Required: all outputs 0 during reset; one cycle after req is applied, gnt=8'b0010_0000, gnt_idx=5.
   - Then drop req[5]: gnt=0 for one cycle, then gnt=8'b0000_0100, gnt_idx=2.
2. Round-robin rotation:
   - Stimulus: mode=1, req=8'hFF held, each granted requester drops its req one cycle after being granted and re-raises it the next cycle.
   - Required: grant index sequence 0,1,2,...,7,0, with exactly one dead cycle between grants.
3. Timeout with MAX_HOLD=4:
   - Stimulus: mode=0, req=8'b1000_0000 held high.
   - Required: gnt high for exactly 4 cycles; timeout=1 in the first gnt=0 cycle; re-grant to index 7 one cycle later.
   - Repeat with mode=1 and req=8'b1000_0001: the grant moves to index 0 after the timeout.
4. en and mid-grant reset:
   - Stimulus: while index 3 is granted, drop en.
   - Required: gnt=0 the next cycle, timeout=0, no new grant while en=0.
   - Stimulus: re-grant, then assert rst mid-grant.
   - Required: all outputs 0 at the next edge and the round-robin search restarts at index 0.
5. Boundary events:
   - req[gnt_idx] drops on the same edge hold_cnt reaches MAX_HOLD: release with timeout=0.
   - req=0 with en=1: no grant ever.
   - Toggling other req bits during a grant: no change to gnt.
